stopwatch_ctrl: RTL and testbench

Control and timebase block for the stopwatch. It sits between the debounced button/switch inputs and the BCD counter datapath that drives `min10/min1/sec10/sec1`. From the single master clock it derives 1 Hz and 2 Hz strobes and runs the run/pause/adjust state machine. It issues one-cycle enables to the datapath: count, adjust-minutes, adjust-seconds and clear. It also drives the blanking controls the display path uses to blink the field being adjusted.

---
 rtl/stopwatch_pkg.sv | 27 ++
 rtl/stopwatch_tick_gen.sv | 49 ++++
 rtl/stopwatch_ctrl.sv | 109 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and helpers for the stopwatch control block:
//               operating mode enum, blank bit indices, divider sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  // Operating mode, derived combinationally from the adj switch and run flag
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    ADJ   = 2'd2
  } mode_t;

  // Bit positions inside the blank vector
  localparam int BLANK_MIN = 1;
  localparam int BLANK_SEC = 0;

  // Number of master clock cycles in one half second
  function automatic int div_half(input int clk_hz);
    return clk_hz / 2;
  endfunction

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/stopwatch_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_tick_gen
// Description : Free-running half-second divider. Produces a 2 Hz strobe,
//               a 1 Hz strobe on every second 2 Hz strobe, and the phase bit
//               that alternates every half second.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_tick_gen
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_deb,
  output logic tick_2hz,
  output logic tick_1hz,
  output logic phase
);

  localparam int c_HALF  = div_half(CLK_HZ);
  localparam int c_CNT_W = (c_HALF > 1) ? $clog2(c_HALF) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_HALF - 1);

  logic [c_CNT_W-1:0] r_div_cnt;
  logic               r_phase;
  logic               w_tick_2hz;

  // Strobes decode straight from the registers, so they carry no latency
  assign w_tick_2hz = (r_div_cnt == c_LAST);
  assign tick_2hz   = w_tick_2hz;
  assign tick_1hz   = w_tick_2hz & r_phase;
  assign phase      = r_phase;

  // Divider counts 0..HALF-1 and wraps; phase flips at every wrap
  always_ff @(posedge clk) begin
    if (rst_deb) begin
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (w_tick_2hz) begin
      r_div_cnt <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule : stopwatch_tick_gen
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch control: timebase, run/pause/adjust mode logic,
//               one-cycle datapath enables, clear and display blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_deb,
  input  logic       pause_deb,
  input  logic       sel,
  input  logic       adj,
  output logic       tick_2hz,
  output logic       tick_1hz,
  output logic       cnt_en,
  output logic       adj_min_en,
  output logic       adj_sec_en,
  output logic       clr,
  output logic [1:0] blank,
  output logic       running
);

  logic       w_tick_2hz;
  logic       w_tick_1hz;
  logic       w_phase;
  logic       w_rise;
  mode_t      w_mode;
  logic [1:0] w_blank_nxt;

  logic       r_run;
  logic       r_pause_prev;
  logic       r_cnt_en;
  logic       r_adj_min_en;
  logic       r_adj_sec_en;
  logic       r_clr;
  logic [1:0] r_blank;

  stopwatch_tick_gen #(
    .CLK_HZ   (CLK_HZ)
  ) u_tick_gen (
    .clk      (clk),
    .rst_deb  (rst_deb),
    .tick_2hz (w_tick_2hz),
    .tick_1hz (w_tick_1hz),
    .phase    (w_phase)
  );

  assign w_rise = pause_deb & ~r_pause_prev;

  // Mode: the adjust switch overrides the run flag, which stays untouched
  always_comb begin
    w_mode = PAUSE;
    if (adj) begin
      w_mode = ADJ;
    end else if (r_run) begin
      w_mode = RUN;
    end
  end

  // Blink the field being adjusted in step with the half-second phase
  always_comb begin
    w_blank_nxt = 2'b00;
    if (w_mode == ADJ) begin
      w_blank_nxt[BLANK_MIN] = ~sel & w_phase;
      w_blank_nxt[BLANK_SEC] =  sel & w_phase;
    end
  end

  // Run flag, edge detector and registered per-mode outputs
  always_ff @(posedge clk) begin
    if (rst_deb) begin
      // Previous level reset high so a button held through reset is no rise
      r_pause_prev <= 1'b1;
      r_run        <= 1'b1;
      r_cnt_en     <= 1'b0;
      r_adj_min_en <= 1'b0;
      r_adj_sec_en <= 1'b0;
      r_clr        <= 1'b1;
      r_blank      <= 2'b00;
    end else begin
      r_pause_prev <= pause_deb;
      if (w_rise && !adj) begin
        r_run <= ~r_run;
      end
      // Enables use the mode of the strobe cycle, before any run toggle
      r_cnt_en     <= (w_mode == RUN) & w_tick_1hz;
      r_adj_min_en <= (w_mode == ADJ) & ~sel & w_tick_2hz;
      r_adj_sec_en <= (w_mode == ADJ) &  sel & w_tick_2hz;
      r_clr        <= 1'b0;
      r_blank      <= w_blank_nxt;
    end
  end

  assign tick_2hz   = w_tick_2hz;
  assign tick_1hz   = w_tick_1hz;
  assign cnt_en     = r_cnt_en;
  assign adj_min_en = r_adj_min_en;
  assign adj_sec_en = r_adj_sec_en;
  assign clr        = r_clr;
  assign blank      = r_blank;
  assign running    = r_run;

endmodule : stopwatch_ctrl
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Self-checking bench for stopwatch_ctrl at CLK_HZ=8. Directed
//               scenarios plus randomized stimulus against a cycle-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int CLK_HZ = 8;
  localparam int HALF   = CLK_HZ / 2;

  logic       clk = 1'b0;
  logic       rst_deb = 1'b1;
  logic       pause_deb = 1'b0;
  logic       sel = 1'b0;
  logic       adj = 1'b0;
  logic       tick_2hz, tick_1hz, cnt_en, adj_min_en, adj_sec_en, clr, running;
  logic [1:0] blank;

  int n_checks = 0;
  int n_errors = 0;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ)) dut (
    .clk        (clk),
    .rst_deb    (rst_deb),
    .pause_deb  (pause_deb),
    .sel        (sel),
    .adj        (adj),
    .tick_2hz   (tick_2hz),
    .tick_1hz   (tick_1hz),
    .cnt_en     (cnt_en),
    .adj_min_en (adj_min_en),
    .adj_sec_en (adj_sec_en),
    .clr        (clr),
    .blank      (blank),
    .running    (running)
  );

  always #5 clk = ~clk;

  // Reference model: time is the cycle count since reset release; strobes
  // and phase follow from modular arithmetic on that count.
  int         m_t = 0;
  logic       m_run = 1'b1;
  logic       m_prev = 1'b1;
  logic       e_cnt = 1'b0, e_amin = 1'b0, e_asec = 1'b0, e_clr = 1'b1;
  logic [1:0] e_blank = 2'b00;

  function automatic logic f_t2(input int t);
    return (t % HALF) == HALF - 1;
  endfunction
  function automatic logic f_t1(input int t);
    return (t % CLK_HZ) == CLK_HZ - 1;
  endfunction
  function automatic logic f_ph(input int t);
    return ((t / HALF) % 2) == 1;
  endfunction

  always @(posedge clk) begin
    if (rst_deb) begin
      m_t <= 0; m_run <= 1'b1; m_prev <= 1'b1;
      e_cnt <= 1'b0; e_amin <= 1'b0; e_asec <= 1'b0; e_clr <= 1'b1; e_blank <= 2'b00;
    end else begin
      e_cnt   <= !adj && m_run && f_t1(m_t);
      e_amin  <= adj && !sel && f_t2(m_t);
      e_asec  <= adj && sel && f_t2(m_t);
      e_blank <= (adj && f_ph(m_t)) ? (sel ? 2'b01 : 2'b10) : 2'b00;
      e_clr   <= 1'b0;
      if (pause_deb && !m_prev && !adj) m_run <= !m_run;
      m_prev  <= pause_deb;
      m_t     <= m_t + 1;
    end
  end

  // Holds reset for n cycles; returns at the negedge of cycle 0
  task automatic apply_reset(input int n);
    @(negedge clk);
    rst_deb = 1'b1; adj = 1'b0; sel = 1'b0;
    repeat (n) @(negedge clk);
    rst_deb = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_deb = 1'b1; adj = 1'b0; sel = 1'b0; pause_deb = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tick_2hz, tick_1hz, cnt_en, adj_min_en, adj_sec_en} !== 5'b0) begin
      n_errors++; $display("FAIL reset_strobes: got %b expected 00000", {tick_2hz, tick_1hz, cnt_en, adj_min_en, adj_sec_en});
    end
    n_checks++;
    if ({clr, blank, running} !== 4'b1001) begin
      n_errors++; $display("FAIL reset_status: got clr/blank/running %b expected 1001", {clr, blank, running});
    end
    rst_deb = 1'b0;
  endtask

  task automatic test_first_ticks();
    for (int t = 0; t <= 24; t++) begin
      n_checks++;
      if (tick_2hz !== ((t % 4) == 3)) begin
        n_errors++; $display("FAIL first_tick_2hz c%0d: got %b expected %b", t, tick_2hz, (t % 4) == 3);
      end
      n_checks++;
      if (tick_1hz !== ((t % 8) == 7)) begin
        n_errors++; $display("FAIL first_tick_1hz c%0d: got %b expected %b", t, tick_1hz, (t % 8) == 7);
      end
      n_checks++;
      if (cnt_en !== (t > 0 && (t % 8) == 0)) begin
        n_errors++; $display("FAIL first_cnt_en c%0d: got %b expected %b", t, cnt_en, t > 0 && (t % 8) == 0);
      end
      n_checks++;
      if (clr !== (t == 0) || running !== 1'b1) begin
        n_errors++; $display("FAIL first_clr_running c%0d: got %b%b expected %b1", t, clr, running, t == 0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pause_resume();
    logic exp_run, exp_cnt;
    pause_deb = 1'b0;
    apply_reset(2);
    for (int t = 0; t <= 30; t++) begin
      exp_run = !(t >= 11 && t < 21);
      exp_cnt = (t == 8 || t == 24);
      n_checks++;
      if (running !== exp_run || cnt_en !== exp_cnt) begin
        n_errors++; $display("FAIL pause_resume c%0d: running/cnt_en got %b%b expected %b%b", t, running, cnt_en, exp_run, exp_cnt);
      end
      pause_deb = (t == 10 || t == 20);
      @(negedge clk);
    end
    pause_deb = 1'b0;
  endtask

  task automatic test_adjust();
    logic s, pulse, ph;
    logic [1:0] exp_blank;
    pause_deb = 1'b0;
    apply_reset(2);
    for (int t = 0; t <= 40; t++) begin
      s         = (t - 1) >= 24;
      pulse     = t > 0 && (t % 4) == 0;
      ph        = (t > 0) && (((t - 1) / 4) % 2 == 1);
      exp_blank = (t == 0) ? 2'b00 : (s ? {1'b0, ph} : {ph, 1'b0});
      n_checks++;
      if (adj_min_en !== (pulse && !s) || adj_sec_en !== (pulse && s) || cnt_en !== 1'b0) begin
        n_errors++; $display("FAIL adjust_en c%0d: min/sec/cnt got %b%b%b expected %b%b0", t, adj_min_en, adj_sec_en, cnt_en, pulse && !s, pulse && s);
      end
      n_checks++;
      if (blank !== exp_blank) begin
        n_errors++; $display("FAIL adjust_blank c%0d: got %b expected %b", t, blank, exp_blank);
      end
      adj = 1'b1;
      sel = (t >= 24);
      @(negedge clk);
    end
  endtask

  task automatic test_pause_in_adj();
    int n_cnt;
    // Running case: pulse while adjusting, flag stays set, counting resumes
    adj = 1'b1; pause_deb = 1'b1;
    @(negedge clk); pause_deb = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (running !== 1'b1) begin
      n_errors++; $display("FAIL adj_pause_ignored_run: got %b expected 1", running);
    end
    adj = 1'b0; n_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cnt += int'(cnt_en);
      n_checks++;
      if (cnt_en !== e_cnt || running !== 1'b1) begin
        n_errors++; $display("FAIL adj_exit_run k%0d: cnt_en/running got %b%b expected %b1", k, cnt_en, running, e_cnt);
      end
    end
    n_checks++;
    if (n_cnt < 2) begin
      n_errors++; $display("FAIL adj_exit_run_count: got %0d expected >=2", n_cnt);
    end
    // Paused case: pause, adjust with a pulse, leave adjust, still paused
    pause_deb = 1'b1; @(negedge clk); pause_deb = 1'b0; @(negedge clk);
    adj = 1'b1; pause_deb = 1'b1; @(negedge clk); pause_deb = 1'b0;
    repeat (3) @(negedge clk);
    adj = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (cnt_en !== 1'b0 || running !== 1'b0) begin
        n_errors++; $display("FAIL adj_exit_pause k%0d: cnt_en/running got %b%b expected 00", k, cnt_en, running);
      end
    end
  endtask

  task automatic test_simultaneous();
    pause_deb = 1'b0;
    apply_reset(2);
    for (int t = 0; t <= 17; t++) begin
      n_checks++;
      if (cnt_en !== (t == 8) || running !== (t < 8)) begin
        n_errors++; $display("FAIL simul_pause_tick c%0d: cnt_en/running got %b%b expected %b%b", t, cnt_en, running, t == 8, t < 8);
      end
      pause_deb = (t == 7);
      @(negedge clk);
    end
    pause_deb = 1'b0;
  endtask

  task automatic test_reset_held();
    pause_deb = 1'b1;
    apply_reset(3);
    for (int t = 0; t <= 10; t++) begin
      n_checks++;
      if (running !== 1'b1 || cnt_en !== (t == 8)) begin
        n_errors++; $display("FAIL held_pause c%0d: running/cnt_en got %b%b expected 1%b", t, running, cnt_en, t == 8);
      end
      pause_deb = (t < 5);
      @(negedge clk);
    end
    pause_deb = 1'b0;
    apply_reset(2);
    for (int t = 0; t <= 7; t++) begin
      if (t == 6) begin
        n_checks++;
        if (blank !== 2'b10) begin
          n_errors++; $display("FAIL mid_adj_blank_pre: got %b expected 10", blank);
        end
      end
      adj = 1'b1;
      rst_deb = (t == 7);
      @(negedge clk);
    end
    n_checks++;
    if ({cnt_en, adj_min_en, adj_sec_en} !== 3'b000 || blank !== 2'b00 || clr !== 1'b1) begin
      n_errors++; $display("FAIL mid_adj_reset: en/blank/clr got %b %b %b expected 000 00 1", {cnt_en, adj_min_en, adj_sec_en}, blank, clr);
    end
    rst_deb = 1'b0; adj = 1'b0;
  endtask

  task automatic test_random();
    pause_deb = 1'b0;
    apply_reset(2);
    for (int k = 0; k < 600; k++) begin
      n_checks++;
      if (tick_2hz !== f_t2(m_t) || tick_1hz !== f_t1(m_t)) begin
        n_errors++; $display("FAIL rand_ticks k%0d: got %b%b expected %b%b", k, tick_2hz, tick_1hz, f_t2(m_t), f_t1(m_t));
      end
      n_checks++;
      if ({cnt_en, adj_min_en, adj_sec_en} !== {e_cnt, e_amin, e_asec}) begin
        n_errors++; $display("FAIL rand_enables k%0d: got %b expected %b", k, {cnt_en, adj_min_en, adj_sec_en}, {e_cnt, e_amin, e_asec});
      end
      n_checks++;
      if (clr !== e_clr || blank !== e_blank || running !== m_run) begin
        n_errors++; $display("FAIL rand_status k%0d: clr/blank/running got %b %b %b expected %b %b %b", k, clr, blank, running, e_clr, e_blank, m_run);
      end
      n_checks++;
      if ($countones({cnt_en, adj_min_en, adj_sec_en}) > 1) begin
        n_errors++; $display("FAIL rand_onehot k%0d: got %b expected at most one set", k, {cnt_en, adj_min_en, adj_sec_en});
      end
      rst_deb = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) pause_deb = ~pause_deb;
      if ($urandom_range(0, 15) == 0) adj = ~adj;
      if ($urandom_range(0, 7) == 0) sel = ~sel;
      @(negedge clk);
    end
    rst_deb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_ticks();
    test_pause_resume();
    test_adjust();
    test_pause_in_adj();
    test_simultaneous();
    test_reset_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_stopwatch_ctrl
`default_nettype wire
